// File: rtl/synth_pkg.sv
// Shared keypad/note types for the synth front end.
package synth_pkg;

  localparam int unsigned NUM_KEYS = 17;
  localparam int unsigned NOTE_W   = 5;

  typedef logic [NOTE_W-1:0]   note_t;
  typedef logic [NUM_KEYS-1:0] keyvec_t;

endpackage : synth_pkg

// File: rtl/key_debounce_encoder_if.sv
// Key vector in, debounced keys and encoded note out.
interface key_debounce_encoder_if;
  import synth_pkg::*;

  keyvec_t sync_keys;
  keyvec_t deb_keys;
  note_t   note_idx;
  logic    note_valid;
  logic    note_change;

  modport master (
    output sync_keys,
    input  deb_keys, note_idx, note_valid, note_change
  );

  modport slave (
    input  sync_keys,
    output deb_keys, note_idx, note_valid, note_change
  );

endinterface : key_debounce_encoder_if

// File: rtl/key_debounce_cell.sv
// One key's debouncer: the state flips after STABLE_SAMPLES consecutive
// differing samples on tick; any matching sample restarts the count.
module key_debounce_cell #(
  parameter int unsigned STABLE_SAMPLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic raw,
  output logic deb
);

  localparam int unsigned CNT_W = $clog2(STABLE_SAMPLES) + 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             deb_q, deb_d;

  always_comb begin
    cnt_d = cnt_q;
    deb_d = deb_q;
    if (tick) begin
      if (raw == deb_q) begin
        cnt_d = '0;
      end else if (cnt_q == CNT_W'(STABLE_SAMPLES - 1)) begin
        deb_d = raw;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      deb_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      deb_q <= deb_d;
    end
  end

  assign deb = deb_q;

endmodule : key_debounce_cell

// File: rtl/key_debounce_encoder.sv
// Debounces the synchronized key vector on a shared slow tick and
// priority-encodes it (lowest index wins) into a registered note.
// Optional NOTE_HOLD_EN: keep the last note when all keys are released.
module key_debounce_encoder
  import synth_pkg::*;
#(
  parameter int unsigned TICK_DIV       = 10000,
  parameter int unsigned STABLE_SAMPLES = 4
) (
  input logic                   clk,
  input logic                   rst,
  key_debounce_encoder_if.slave bus
);

  localparam int unsigned TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
  logic              tick_c;
  keyvec_t           deb_keys_c;

  note_t note_idx_q, note_idx_d;
  logic  note_valid_q, note_valid_d;
  logic  note_change_q, note_change_d;
  note_t next_idx_c;
  logic  next_valid_c;

  // Sample tick: high in the last cycle of each TICK_DIV period.
  always_comb begin
    tick_c     = (tick_cnt_q == TICK_W'(TICK_DIV - 1));
    tick_cnt_d = tick_c ? '0 : tick_cnt_q + TICK_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) tick_cnt_q <= '0;
    else     tick_cnt_q <= tick_cnt_d;
  end

  for (genvar g = 0; g < int'(NUM_KEYS); g++) begin : g_key
    key_debounce_cell #(
      .STABLE_SAMPLES (STABLE_SAMPLES)
    ) u_cell (
      .clk  (clk),
      .rst  (rst),
      .tick (tick_c),
      .raw  (bus.sync_keys[g]),
      .deb  (deb_keys_c[g])
    );
  end

  // Lowest set key wins; scan downwards so the last hit is the lowest.
  always_comb begin
    next_valid_c = 1'b0;
    next_idx_c   = '0;
    for (int i = int'(NUM_KEYS) - 1; i >= 0; i--) begin
      if (deb_keys_c[i]) begin
        next_valid_c = 1'b1;
        next_idx_c   = NOTE_W'(i);
      end
    end
  end

  always_comb begin
    note_idx_d    = next_idx_c;
    note_valid_d  = next_valid_c;
`ifdef NOTE_HOLD_EN
    // Sustain: an empty keyboard keeps the last note.
    if (!next_valid_c) begin
      note_idx_d   = note_idx_q;
      note_valid_d = note_valid_q;
    end
`endif
    note_change_d = (note_idx_d != note_idx_q) || (note_valid_d != note_valid_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      note_idx_q    <= '0;
      note_valid_q  <= 1'b0;
      note_change_q <= 1'b0;
    end else begin
      note_idx_q    <= note_idx_d;
      note_valid_q  <= note_valid_d;
      note_change_q <= note_change_d;
    end
  end

  assign bus.deb_keys    = deb_keys_c;
  assign bus.note_idx    = note_idx_q;
  assign bus.note_valid  = note_valid_q;
  assign bus.note_change = note_change_q;

endmodule : key_debounce_encoder

// File: tb/tb_key_debounce_encoder.sv
// Directed bench for key_debounce_encoder with TICK_DIV=4, STABLE_SAMPLES=3.
module tb_key_debounce_encoder;

  logic clk = 1'b0;
  logic rst;
  int   n_assert = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  key_debounce_encoder_if kif ();

  key_debounce_encoder #(
    .TICK_DIV       (4),
    .STABLE_SAMPLES (3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (kif.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (cyc %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic chk_note(input string tag, input logic [4:0] idx, input logic vld, input logic chg);
    chk({tag, "_idx"}, 32'(kif.note_idx), 32'(idx));
    chk({tag, "_valid"}, 32'(kif.note_valid), 32'(vld));
    chk({tag, "_change"}, 32'(kif.note_change), 32'(chg));
  endtask

  // Advance to the negedge following rising edge number t after reset release.
  task automatic adv_to(input int t);
    while (cyc < t) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  // Same, but note_change must stay low at every cycle on the way.
  task automatic quiet_to(input string tag, input int t);
    while (cyc < t) begin
      @(negedge clk);
      cyc++;
      chk(tag, 32'(kif.note_change), 32'd0);
    end
  endtask

  initial begin
    rst = 1'b1;
    kif.sync_keys = 17'h1FFFF;

    // 1: reset holds everything at zero, then the first debounce of all keys
    repeat (3) begin
      @(negedge clk);
      chk("rst_deb", 32'(kif.deb_keys), 32'd0);
      chk_note("rst", 5'd0, 1'b0, 1'b0);
    end
    rst = 1'b0;
    cyc = 0;
    adv_to(4);
    chk("t1_deb_c4", 32'(kif.deb_keys), 32'd0);
    quiet_to("t1_quiet", 11);
    chk("t1_deb_c11", 32'(kif.deb_keys), 32'd0);
    adv_to(12);
    chk("t1_deb_c12", 32'(kif.deb_keys), 32'h1FFFF);
    chk_note("t1_c12", 5'd0, 1'b0, 1'b0);
    adv_to(13);
    chk_note("t1_c13", 5'd0, 1'b1, 1'b1);
    adv_to(14);
    chk_note("t1_c14", 5'd0, 1'b1, 1'b0);

    // 2: only key 5 held
    kif.sync_keys = 17'h00020;
    quiet_to("t2_quiet", 23);
    chk("t2_deb_c23", 32'(kif.deb_keys), 32'h1FFFF);
    adv_to(24);
    chk("t2_deb_c24", 32'(kif.deb_keys), 32'h00020);
    chk_note("t2_c24", 5'd0, 1'b1, 1'b0);
    adv_to(25);
    chk_note("t2_c25", 5'd5, 1'b1, 1'b1);
    adv_to(26);
    chk_note("t2_c26", 5'd5, 1'b1, 1'b0);

    // 3: key 7 glitch - two high samples, one low, two high, then low
    kif.sync_keys = 17'h000A0;
    quiet_to("t3_quiet", 33);
    kif.sync_keys = 17'h00020;
    quiet_to("t3_quiet", 37);
    chk("t3_deb_c37", 32'(kif.deb_keys), 32'h00020);
    kif.sync_keys = 17'h000A0;
    quiet_to("t3_quiet", 45);
    kif.sync_keys = 17'h00020;
    quiet_to("t3_quiet", 48);
    chk("t3_deb_c48", 32'(kif.deb_keys), 32'h00020);
    chk_note("t3_c48", 5'd5, 1'b1, 1'b0);

    // 4: priority - key 9 alone, add 3, add 12, drop 3
    kif.sync_keys = 17'h00200;
    quiet_to("t4a_quiet", 60);
    chk("t4_deb_c60", 32'(kif.deb_keys), 32'h00200);
    adv_to(61);
    chk_note("t4_c61", 5'd9, 1'b1, 1'b1);
    adv_to(62);
    chk_note("t4_c62", 5'd9, 1'b1, 1'b0);
    kif.sync_keys = 17'h00208;
    quiet_to("t4b_quiet", 72);
    chk("t4_deb_c72", 32'(kif.deb_keys), 32'h00208);
    adv_to(73);
    chk_note("t4_c73", 5'd3, 1'b1, 1'b1);
    adv_to(74);
    kif.sync_keys = 17'h01208;
    quiet_to("t4c_quiet", 84);
    chk("t4_deb_c84", 32'(kif.deb_keys), 32'h01208);
    quiet_to("t4c_quiet", 88);
    chk_note("t4_c88", 5'd3, 1'b1, 1'b0);
    kif.sync_keys = 17'h01200;
    quiet_to("t4d_quiet", 100);
    chk("t4_deb_c100", 32'(kif.deb_keys), 32'h01200);
    adv_to(101);
    chk_note("t4_c101", 5'd9, 1'b1, 1'b1);
    adv_to(102);
    chk_note("t4_c102", 5'd9, 1'b1, 1'b0);

    // 5: release everything
    kif.sync_keys = 17'h00000;
    quiet_to("t5_quiet", 112);
    chk("t5_deb_c112", 32'(kif.deb_keys), 32'd0);
    adv_to(113);
`ifdef NOTE_HOLD_EN
    chk_note("t5_c113", 5'd9, 1'b1, 1'b0);
`else
    chk_note("t5_c113", 5'd0, 1'b0, 1'b1);
`endif
    adv_to(114);
    chk("t5_chg_c114", 32'(kif.note_change), 32'd0);

    // 6: reset while key 0 is two samples into its debounce
    kif.sync_keys = 17'h00001;
    adv_to(121);
    chk("t6_deb_c121", 32'(kif.deb_keys), 32'd0);
    rst = 1'b1;
    adv_to(122);
    rst = 1'b0;
    chk("t6_deb_c122", 32'(kif.deb_keys), 32'd0);
    chk_note("t6_c122", 5'd0, 1'b0, 1'b0);
    quiet_to("t6_quiet", 125);
    chk("t6_deb_c125", 32'(kif.deb_keys), 32'd0);
    quiet_to("t6_quiet", 133);
    chk("t6_deb_c133", 32'(kif.deb_keys), 32'd0);
    adv_to(134);
    chk("t6_deb_c134", 32'(kif.deb_keys), 32'h00001);
    adv_to(135);
    chk_note("t6_c135", 5'd0, 1'b1, 1'b1);
    adv_to(136);
    chk_note("t6_c136", 5'd0, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule : tb_key_debounce_encoder

// File: doc/key_debounce_encoder.md
Name: key_debounce_encoder

Overview:
Consumes the 17-bit double-flop-synchronized key vector and debounces each key against a shared slow sample tick. It then priority-encodes the debounced vector into a single active note index for the tone generator. Sits directly downstream of the key synchronizer and upstream of the oscillator/note-select logic.

Parameters:
NUM_KEYS, 17, number of key inputs (fixed by keypad; package constant).
TICK_DIV, 10000, clk cycles per debounce sample tick; legal range >= 1; 1 = sample every cycle.
STABLE_SAMPLES, 4, consecutive ticks a key must differ from its debounced state before the state flips; legal range >= 1.

Ports:
clk  in  1  system clock.
rst  in  1  synchronous, active-high reset.
sync_keys  in  NUM_KEYS  synchronized raw key levels, 1 = pressed.
deb_keys  out  NUM_KEYS  debounced key levels, registered.
note_idx  out  5  index of the active key (0..16), registered.
note_valid  out  1  1 = note_idx names a pressed key.
note_change  out  1  single-cycle pulse when (note_valid, note_idx) changes.

Behaviour:
- Reset: synchronous. rst high at a clk edge clears tick counter, all per-key counters, deb_keys, note_idx, note_valid and note_change to 0. rst dominates all other activity; asserting it mid-debounce discards partial counts.
- Tick counter: counts 0..TICK_DIV-1.
  - tick = 1 in the cycle where count == TICK_DIV-1; the counter wraps to 0 on the next edge.
  - TICK_DIV=1 gives tick = 1 every cycle.
  - First tick after reset occurs in cycle TICK_DIV-1.
- Per-key debounce (key i), evaluated only on cycles with tick = 1:
  - sync_keys[i] == deb_keys[i]: cnt_i <= 0.
  - Else if cnt_i == STABLE_SAMPLES-1: deb_keys[i] <= sync_keys[i] and cnt_i <= 0.
  - Else: cnt_i <= cnt_i + 1.
  - cnt_i width is $clog2(STABLE_SAMPLES)+1 and never exceeds STABLE_SAMPLES-1.
  - Without a tick, all counters and deb_keys hold.
  - Any matching sample restarts the count (glitch rejection).
  - The same rule applies to press and release.
- Encoder:
  - Combinational from deb_keys: lowest set index wins. If any key is set, next_valid = 1; if none, next_valid = 0 and next_idx = 0.
  - Registered stage: if (next_valid, next_idx) != (note_valid, note_idx), update both and set note_change = 1 for exactly that one cycle; otherwise hold and note_change = 0.
- Latency: deb_keys flips on edge E (a tick edge); note_idx, note_valid and note_change update on edge E+1. Total from a stable raw input to note_change is STABLE_SAMPLES ticks plus 1 cycle.
- Simultaneous events: several keys flipping on the same tick produce one encoder update and one note_change pulse.
- A change in deb_keys that does not alter the lowest-set key gives no pulse (e.g. adding a higher key).

Optional Feature:
NOTE_HOLD_EN:
- Defined: when deb_keys becomes all-zero, note_idx and note_valid hold their last values and note_change does not pulse (sustain). The next press of any key updates normally, and pulses only if its index differs from the held one. Reset still clears to 0.
- Undefined: release-to-empty drives note_valid = 0 and note_idx = 0, and pulses note_change.

Decomposition:
- Shared package synth_pkg: NUM_KEYS = 17; NOTE_W = 5; typedef logic [NOTE_W-1:0] note_t; typedef logic [NUM_KEYS-1:0] keyvec_t.
- One natural sub-module: key_debounce_cell, a single key's counter and state with inputs clk, rst, tick, raw; output deb. Instantiated NUM_KEYS times with a generate loop.
- Tick counter and encoder stay in the top module.

Test Plan:
Bench parameters: TICK_DIV=4, STABLE_SAMPLES=3.
1. Reset: hold rst 3 cycles with sync_keys=17'h1FFFF -> all outputs 0 throughout. Release -> deb_keys still 0 until the 3rd tick (cycle 11 after release); note_change pulses 1 cycle later.
2. Clean press key 5 held -> deb_keys=17'h00020 after 3 ticks; next cycle note_idx=5, note_valid=1, one-cycle note_change.
3. Glitch on key 7: high for 2 ticks, low for 1 tick, high for 2 ticks -> deb_keys[7] never set; no note_change.
4. Priority: keys 9 then 3 debounced -> note_idx 9 then 3, two pulses. Then key 12 added -> no pulse. Release key 3 -> note_idx=9 with a pulse.
5. Release all from note 9 -> without NOTE_HOLD_EN: note_valid=0, note_idx=0, pulse. With NOTE_HOLD_EN: note_idx stays 9, note_valid stays 1, no pulse.
6. Assert rst one cycle mid-debounce (cnt=2 on key 0) -> all cleared. Key 0 then needs 3 fresh ticks to register.
